// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared definitions for the RV32 sequencing controller.
// Holds the architectural state encoding (also used by the bench to detect
// BREAK), the ALU operation select, the instruction field layout, the R-type
// field constants and a helper that classifies an R-type ADD/SUB.
package core_ctrl_pkg;

    // Architectural controller state; the encoding is externally visible.
    typedef enum logic [2:0] {
        RESET     = 3'b000,
        FETCH     = 3'b001,
        DECODE    = 3'b010,
        EXECUTE   = 3'b011,
        WRITEBACK = 3'b100,
        BREAK     = 3'b110,
        ERROR     = 3'b111
    } ctrl_state_t;

    // ALU operation select; 4 bits leaves room for the rest of RV32I.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1
    } alu_op_t;

    // Base R-type instruction layout.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [2:0]  F3_ADD_SUB = 3'b000;
    localparam logic [6:0]  F7_ADD     = 7'b0000000;
    localparam logic [6:0]  F7_SUB     = 7'b0100000;
    // EBREAK is used as the program terminator.
    localparam logic [31:0] HALT_INSN  = 32'h0010_0073;

    // Returns {valid, alu_op}; valid only for R-type ADD or SUB.
    function automatic logic [4:0] decode_rtype(input instruction_t insn);
        logic [4:0] res;
        res = {1'b0, ALU_ADD};
        if ((insn.opcode == OPC_OP) && (insn.funct3 == F3_ADD_SUB)) begin
            case (insn.funct7)
                F7_ADD:  res = {1'b1, ALU_ADD};
                F7_SUB:  res = {1'b1, ALU_SUB};
                default: res = {1'b0, ALU_ADD};
            endcase
        end else begin
            res = {1'b0, ALU_ADD};
        end
        return res;
    endfunction

endpackage

// File: rtl/core_decode.sv
// core_decode: purely combinational instruction decoder.
// Ports:
//   ir_i         instruction register contents
//   rs1_o/rs2_o  source register indices
//   rd_o         destination register index
//   alu_op_o     ALU select for a valid ADD/SUB (ALU_ADD otherwise)
//   is_halt_o    instruction is the HALT word
//   is_illegal_o instruction is neither HALT nor a supported R-type
module core_decode
    import core_ctrl_pkg::*;
(
    input  instruction_t ir_i,
    output logic [4:0]   rs1_o,
    output logic [4:0]   rs2_o,
    output logic [4:0]   rd_o,
    output alu_op_t      alu_op_o,
    output logic         is_halt_o,
    output logic         is_illegal_o
);

    logic [4:0] rtype_s;
    logic       halt_s;

    assign rtype_s      = decode_rtype(ir_i);
    assign halt_s       = (ir_i == HALT_INSN);
    assign rs1_o        = ir_i.rs1;
    assign rs2_o        = ir_i.rs2;
    assign rd_o         = ir_i.rd;
    assign alu_op_o     = alu_op_t'(rtype_s[3:0]);
    assign is_halt_o    = halt_s;
    assign is_illegal_o = ~halt_s & ~rtype_s[4];

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle sequencing FSM for the RV32 integer core.
// Fetches one word per instruction, decodes R-type ADD/SUB and HALT, and
// drives register-file and ALU controls. Every output comes from a register.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   imem_req/addr        fetch request and word address (= pc)
//   imem_ack/rdata       fetch data valid strobe and instruction word
//   rf_raddr1/2, waddr   register-file indices (rs1, rs2, rd)
//   rf_we                one-cycle write strobe in WRITEBACK (never for x0)
//   alu_op               ALU select
//   state, pc, retired   architectural state, pc, retired-instruction count
//   illegal              sticky: undecodable instruction or fetch timeout
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  instruction_t      imem_rdata,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    output logic [4:0]        rf_waddr,
    output logic              rf_we,
    output alu_op_t           alu_op,
    output ctrl_state_t       state,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       retired,
    output logic              illegal
);

    localparam int TO_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(FETCH_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    ctrl_state_t       state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [31:0]       retired_q,   retired_d;
    logic              illegal_q,   illegal_d;
    logic              imem_req_q,  imem_req_d;
    logic              rf_we_q,     rf_we_d;
    logic [4:0]        raddr1_q,    raddr1_d;
    logic [4:0]        raddr2_q,    raddr2_d;
    logic [4:0]        waddr_q,     waddr_d;
    alu_op_t           alu_op_q,    alu_op_d;
    instruction_t      ir_q,        ir_d;
    logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;

    logic [4:0]        dec_rs1_s;
    logic [4:0]        dec_rs2_s;
    logic [4:0]        dec_rd_s;
    alu_op_t           dec_alu_op_s;
    logic              dec_halt_s;
    logic              dec_illegal_s;

    core_decode u_decode (
        .ir_i         (ir_q),
        .rs1_o        (dec_rs1_s),
        .rs2_o        (dec_rs2_s),
        .rd_o         (dec_rd_s),
        .alu_op_o     (dec_alu_op_s),
        .is_halt_o    (dec_halt_s),
        .is_illegal_o (dec_illegal_s)
    );

    // Next-state and next-output logic; strobes default low each cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        retired_d  = retired_q;
        illegal_d  = illegal_q;
        imem_req_d = 1'b0;
        rf_we_d    = 1'b0;
        raddr1_d   = raddr1_q;
        raddr2_d   = raddr2_q;
        waddr_d    = waddr_q;
        alu_op_d   = alu_op_q;
        ir_d       = ir_q;
        to_cnt_d   = to_cnt_q;

        case (state_q)
            RESET: begin
                state_d    = FETCH;
                imem_req_d = 1'b1;
            end
            FETCH: begin
                if (imem_ack) begin
                    ir_d     = imem_rdata;
                    to_cnt_d = {TO_W{1'b0}};
                    state_d  = DECODE;
                end else if (to_cnt_q == TO_LAST) begin
                    // This unacknowledged cycle is the FETCH_TIMEOUT-th one.
                    to_cnt_d  = to_cnt_q + TO_ONE;
                    illegal_d = 1'b1;
                    state_d   = ERROR;
                end else begin
                    to_cnt_d   = to_cnt_q + TO_ONE;
                    imem_req_d = 1'b1;
                end
            end
            DECODE: begin
                raddr1_d = dec_rs1_s;
                raddr2_d = dec_rs2_s;
                waddr_d  = dec_rd_s;
                if (dec_halt_s) begin
                    state_d = BREAK;
                end else if (dec_illegal_s) begin
                    illegal_d = 1'b1;
                    state_d   = ERROR;
                end else begin
                    alu_op_d = dec_alu_op_s;
                    state_d  = EXECUTE;
                end
            end
            EXECUTE: begin
                // Strobe is registered, so it is armed here and seen in WRITEBACK.
                rf_we_d = (waddr_q != 5'd0);
                state_d = WRITEBACK;
            end
            WRITEBACK: begin
                pc_d       = pc_q + PC_ONE;
                retired_d  = retired_q + 32'd1;
                imem_req_d = 1'b1;
                state_d    = FETCH;
            end
            BREAK: begin
                state_d = BREAK;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                // Unused encoding: fail safe.
                illegal_d = 1'b1;
                state_d   = ERROR;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET;
            pc_q       <= {ADDR_W{1'b0}};
            retired_q  <= 32'd0;
            illegal_q  <= 1'b0;
            imem_req_q <= 1'b0;
            rf_we_q    <= 1'b0;
            raddr1_q   <= 5'd0;
            raddr2_q   <= 5'd0;
            waddr_q    <= 5'd0;
            alu_op_q   <= ALU_ADD;
            ir_q       <= 32'd0;
            to_cnt_q   <= {TO_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
            illegal_q  <= illegal_d;
            imem_req_q <= imem_req_d;
            rf_we_q    <= rf_we_d;
            raddr1_q   <= raddr1_d;
            raddr2_q   <= raddr2_d;
            waddr_q    <= waddr_d;
            alu_op_q   <= alu_op_d;
            ir_q       <= ir_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign rf_raddr1 = raddr1_q;
    assign rf_raddr2 = raddr2_q;
    assign rf_waddr  = waddr_q;
    assign rf_we     = rf_we_q;
    assign alu_op    = alu_op_q;
    assign state     = state_q;
    assign pc        = pc_q;
    assign retired   = retired_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed self-checking bench for core_ctrl.
// A program-level model expands each test program into the per-cycle trace of
// expected outputs; one loop compares the DUT against it every cycle, and a
// few hand-computed literals pin the model itself.
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    localparam int TB_TIMEOUT = 8;

    logic         clk;
    logic         rst;
    logic         imem_req;
    logic [15:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic [4:0]   rf_raddr1;
    logic [4:0]   rf_raddr2;
    logic [4:0]   rf_waddr;
    logic         rf_we;
    alu_op_t      alu_op;
    ctrl_state_t  state;
    logic [15:0]  pc;
    logic [31:0]  retired;
    logic         illegal;

    core_ctrl #(.ADDR_W(16), .FETCH_TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .alu_op     (alu_op),
        .state      (state),
        .pc         (pc),
        .retired    (retired),
        .illegal    (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory responder ----------------
    logic [31:0] mem [0:15];
    int          ack_delay;
    bit          never_ack;

    initial begin
        int wcnt;
        wcnt       = 0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            imem_rdata = mem[imem_addr[3:0]];
            if (imem_req === 1'b1 && !never_ack) begin
                if (wcnt == ack_delay) begin
                    imem_ack = 1'b1;
                    wcnt     = 0;
                end else begin
                    imem_ack = 1'b0;
                    wcnt     = wcnt + 1;
                end
            end else begin
                imem_ack = 1'b0;
                wcnt     = 0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- program-level model ----------------
    typedef struct {
        ctrl_state_t st;
        logic        req;
        logic [15:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [4:0]  r1;
        logic [4:0]  r2;
        alu_op_t     op;
        logic [31:0] ret;
        logic        ill;
    } row_t;

    row_t        exp_q[$];
    logic [15:0] m_pc;
    logic [31:0] m_ret;
    logic        m_ill;
    logic [4:0]  m_wa, m_r1, m_r2;
    alu_op_t     m_op;

    task automatic model_reset();
        m_pc  = 16'd0;
        m_ret = 32'd0;
        m_ill = 1'b0;
        m_wa  = 5'd0;
        m_r1  = 5'd0;
        m_r2  = 5'd0;
        m_op  = ALU_ADD;
    endtask

    task automatic push_row(input ctrl_state_t st, input logic req, input logic we);
        row_t r;
        r.st  = st;
        r.req = req;
        r.pc  = m_pc;
        r.we  = we;
        r.wa  = m_wa;
        r.r1  = m_r1;
        r.r2  = m_r2;
        r.op  = m_op;
        r.ret = m_ret;
        r.ill = m_ill;
        exp_q.push_back(r);
    endtask

    // Expand the program in mem[] into cycles, starting at the first FETCH.
    task automatic gen_run();
        logic [31:0] insn;
        for (int n = 0; n < 16; n++) begin
            if (never_ack) begin
                for (int k = 0; k < TB_TIMEOUT; k++) push_row(FETCH, 1'b1, 1'b0);
                m_ill = 1'b1;
                for (int k = 0; k < 4; k++) push_row(ERROR, 1'b0, 1'b0);
                return;
            end
            for (int k = 0; k <= ack_delay; k++) push_row(FETCH, 1'b1, 1'b0);
            push_row(DECODE, 1'b0, 1'b0);
            insn = mem[m_pc[3:0]];
            if (insn == HALT_INSN) begin
                for (int k = 0; k < 4; k++) push_row(BREAK, 1'b0, 1'b0);
                return;
            end
            if (insn[6:0] == 7'h33 && insn[14:12] == 3'd0 &&
                (insn[31:25] == 7'h00 || insn[31:25] == 7'h20)) begin
                m_r1 = insn[19:15];
                m_r2 = insn[24:20];
                m_wa = insn[11:7];
                m_op = (insn[31:25] == 7'h20) ? ALU_SUB : ALU_ADD;
                push_row(EXECUTE, 1'b0, 1'b0);
                push_row(WRITEBACK, 1'b0, (m_wa != 5'd0));
                m_pc  = m_pc + 16'd1;
                m_ret = m_ret + 32'd1;
            end else begin
                m_ill = 1'b1;
                for (int k = 0; k < 4; k++) push_row(ERROR, 1'b0, 1'b0);
                return;
            end
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic load_prog(input logic [31:0] w0, input logic [31:0] w1);
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[0] = w0;
        mem[1] = w1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state",   32'(state),     32'd0);
        chk("rst_pc",      32'(pc),        32'd0);
        chk("rst_retired", retired,        32'd0);
        chk("rst_illegal", 32'(illegal),   32'd0);
        chk("rst_req",     32'(imem_req),  32'd0);
        chk("rst_we",      32'(rf_we),     32'd0);
        chk("rst_raddr1",  32'(rf_raddr1), 32'd0);
        chk("rst_raddr2",  32'(rf_raddr2), 32'd0);
        chk("rst_waddr",   32'(rf_waddr),  32'd0);
        chk("rst_aluop",   32'(alu_op),    32'(ALU_ADD));
        rst = 1'b0;
    endtask

    int          wb_idx, we_cnt, req_run;
    logic [4:0]  cap_wa, cap_r1, cap_r2;
    alu_op_t     cap_op;

    // Reset, expand the model, then compare every cycle of the trace.
    task automatic run_case(input int delay, input bit nack, input int rst_at);
        row_t e;
        ack_delay = delay;
        never_ack = nack;
        do_reset();
        model_reset();
        exp_q.delete();
        gen_run();
        if (rst_at >= 0) begin
            while (exp_q.size() > rst_at + 1) void'(exp_q.pop_back());
            model_reset();
            push_row(RESET, 1'b0, 1'b0);
            gen_run();
        end
        wb_idx  = -1;
        we_cnt  = 0;
        req_run = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            e = exp_q[i];
            chk("state",    32'(state),    32'(e.st));
            chk("imem_req", 32'(imem_req), 32'(e.req));
            chk("pc",       32'(pc),       32'(e.pc));
            chk("rf_we",    32'(rf_we),    32'(e.we));
            chk("retired",  retired,       e.ret);
            chk("illegal",  32'(illegal),  32'(e.ill));
            if (e.req) chk("imem_addr", 32'(imem_addr), 32'(e.pc));
            if (e.st == EXECUTE || e.st == WRITEBACK) begin
                chk("rf_raddr1", 32'(rf_raddr1), 32'(e.r1));
                chk("rf_raddr2", 32'(rf_raddr2), 32'(e.r2));
                chk("rf_waddr",  32'(rf_waddr),  32'(e.wa));
                chk("alu_op",    32'(alu_op),    32'(e.op));
            end
            if (rf_we === 1'b1) begin
                if (wb_idx < 0) begin
                    wb_idx = i;
                    cap_wa = rf_waddr;
                    cap_r1 = rf_raddr1;
                    cap_r2 = rf_raddr2;
                    cap_op = alu_op;
                end
                we_cnt++;
            end
            if (imem_req === 1'b1 && i == req_run) req_run++;
            rst = (i == rst_at);
        end
        rst = 1'b0;
    endtask

    initial begin
        int wb_base;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        ack_delay = 0;
        never_ack = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;

        // 1: ADD x1,x2,x3 then HALT, zero-wait memory.
        load_prog(enc_r(7'h00, 5'd1, 5'd2, 5'd3), HALT_INSN);
        run_case(0, 1'b0, -1);
        wb_base = wb_idx;
        chk("t1_state",   32'(state),  32'h6);
        chk("t1_pc",      32'(pc),     32'd1);
        chk("t1_retired", retired,     32'd1);
        chk("t1_we_cnt",  32'(we_cnt), 32'd1);
        chk("t1_wb_idx",  32'(wb_idx), 32'd3);
        chk("t1_waddr",   32'(cap_wa), 32'd1);
        chk("t1_raddr1",  32'(cap_r1), 32'd2);
        chk("t1_raddr2",  32'(cap_r2), 32'd3);
        chk("t1_aluop",   32'(cap_op), 32'(ALU_ADD));

        // 2: SUB into x0 retires without a write strobe.
        load_prog(enc_r(7'h20, 5'd0, 5'd4, 5'd5), HALT_INSN);
        run_case(0, 1'b0, -1);
        chk("t2_state",   32'(state),  32'h6);
        chk("t2_we_cnt",  32'(we_cnt), 32'd0);
        chk("t2_retired", retired,     32'd1);
        chk("t2_pc",      32'(pc),     32'd1);

        // 3: program 1 with a 5-cycle fetch wait.
        load_prog(enc_r(7'h00, 5'd1, 5'd2, 5'd3), HALT_INSN);
        run_case(5, 1'b0, -1);
        chk("t3_req_cycles", 32'(req_run), 32'd6);
        chk("t3_wb_idx",     32'(wb_idx),  32'd8);
        chk("t3_wb_shift",   32'(wb_idx - wb_base), 32'd5);
        chk("t3_state",      32'(state),   32'h6);

        // 4: fetch never acknowledged -> timeout.
        run_case(0, 1'b1, -1);
        chk("t4_fetch_cycles", 32'(req_run), 32'd8);
        chk("t4_state",        32'(state),   32'h7);
        chk("t4_illegal",      32'(illegal), 32'd1);

        // 5: ADDI is not decodable.
        load_prog(32'h0000_0013, HALT_INSN);
        run_case(0, 1'b0, -1);
        chk("t5_state",   32'(state),   32'h7);
        chk("t5_illegal", 32'(illegal), 32'd1);
        chk("t5_we_cnt",  32'(we_cnt),  32'd0);
        chk("t5_retired", retired,      32'd0);

        // 6: reset pulse during EXECUTE of the first instruction, then rerun.
        load_prog(enc_r(7'h00, 5'd1, 5'd2, 5'd3), HALT_INSN);
        run_case(0, 1'b0, 2);
        chk("t6_we_cnt",  32'(we_cnt), 32'd1);
        chk("t6_wb_idx",  32'(wb_idx), 32'd7);
        chk("t6_state",   32'(state),  32'h6);
        chk("t6_pc",      32'(pc),     32'd1);
        chk("t6_retired", retired,     32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
